bram_burst_master: RTL and testbench

//  Requester-side controller for the banked BRAM array: accepts burst read/write commands
//  and drives the array's rd_en/wr_en/rd_addr/wr_addr/data_in ports, absorbing the array's
//  1-cycle read latency. Read data leaves on a valid/ready stream with backpressure.

---
 rtl/bram_burst_master.sv | 181 ++++++++++++++++++
 tb/tb_bram_burst_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_burst_master.sv
// rtl/bram_burst_master.sv - burst read/write requester for the banked BRAM array
//
// Purpose: turns burst commands into per-beat strobes on the BRAM array and
// streams read data out through a small FIFO with backpressure.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   cmd_*           burst command handshake (write flag, start address, beats-1)
//   wdata_*         write beat stream, accepted only while a write burst runs
//   rdata_*         read beat stream towards the consumer
//   busy, done      burst in progress / one-cycle completion pulse
//   mem_*           registered strobes to the array; mem_rdata comes back from it
module bram_burst_master #(
  parameter  int NUM_BLOCKS = 16,
  parameter  int LEN_W      = 8,
  localparam int ADDR_W     = 8 + $clog2(NUM_BLOCKS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [15:0]       wdata,
  output logic              rdata_valid,
  input  logic              rdata_ready,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [15:0]       mem_wdata,
  input  logic [15:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  localparam logic [LEN_W:0]    ONE_BEAT = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   addr, addr_nxt;
  logic [LEN_W:0]      beats, beats_nxt;     // beats still to issue
  logic                rd_en_nxt, wr_en_nxt, done_nxt;
  logic [ADDR_W-1:0]   rd_addr_nxt, wr_addr_nxt;
  logic [15:0]         wdata_nxt;

  // inflight: mem_rdata carries the data of the read issued last cycle.
  logic                inflight;
  logic [15:0]         fifo_q [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          fifo_count;
  logic                fifo_empty, pop, push, fifo_pop, issue_ok;
  logic [2:0]          outstanding;

  assign cmd_ready   = (state == IDLE);
  assign wdata_ready = (state == WRITE);
  assign busy        = (state != IDLE);

  // The in-flight beat is presented straight from mem_rdata when the FIFO is
  // empty, so a stream with rdata_ready high sees no bubble. If it is not
  // taken it drops into the FIFO and holds the same value next cycle.
  assign fifo_empty  = (fifo_count == 2'd0);
  assign rdata_valid = !fifo_empty || inflight;
  assign rdata       = !fifo_empty ? fifo_q[rd_ptr] : (inflight ? mem_rdata : 16'h0000);
  assign pop         = rdata_valid && rdata_ready;
  assign fifo_pop    = pop && !fifo_empty;
  assign push        = inflight && !(pop && fifo_empty);

  // Every issued read must have a FIFO slot even if the consumer stalls from
  // now on; the beat leaving this cycle frees one.
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight} + {2'b00, mem_rd_en};
  assign issue_ok    = outstanding < (3'd2 + {2'b00, pop});

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    beats_nxt   = beats;
    rd_en_nxt   = 1'b0;
    wr_en_nxt   = 1'b0;
    done_nxt    = 1'b0;
    rd_addr_nxt = mem_rd_addr;
    wr_addr_nxt = mem_wr_addr;
    wdata_nxt   = mem_wdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_nxt  = cmd_addr;
          beats_nxt = {1'b0, cmd_len} + ONE_BEAT;
          state_nxt = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        if (wdata_valid) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = addr;
          wdata_nxt   = wdata;
          addr_nxt    = addr + ADDR_ONE;
          beats_nxt   = beats - ONE_BEAT;
          if (beats == ONE_BEAT) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      READ: begin
        if (issue_ok) begin
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = addr;
          addr_nxt    = addr + ADDR_ONE;
          beats_nxt   = beats - ONE_BEAT;
          if (beats == ONE_BEAT) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Finish on the edge that delivers the last outstanding beat.
        if (outstanding == {2'b00, pop}) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      beats       <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wdata   <= '0;
      done        <= 1'b0;
      inflight    <= 1'b0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      beats       <= beats_nxt;
      mem_rd_en   <= rd_en_nxt;
      mem_rd_addr <= rd_addr_nxt;
      mem_wr_en   <= wr_en_nxt;
      mem_wr_addr <= wr_addr_nxt;
      mem_wdata   <= wdata_nxt;
      done        <= done_nxt;
      inflight    <= mem_rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= mem_rdata;
        wr_ptr         <= ~wr_ptr;
      end
      if (fifo_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_burst_master.sv
// tb/tb_bram_burst_master.sv - self-checking bench for bram_burst_master
module tb_bram_burst_master;

  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid, rdata_ready;
  logic [15:0] rdata;
  logic        busy, done;
  logic        mem_rd_en, mem_wr_en;
  logic [11:0] mem_rd_addr, mem_wr_addr;
  logic [15:0] mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  // Array attached to the DUT, and the bench's own view of what it must hold.
  logic [15:0] bram    [DEPTH];
  logic [15:0] ref_mem [DEPTH];

  always #5 clk = ~clk;

  bram_burst_master #(.NUM_BLOCKS(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // One-cycle-latency array: data_out valid the cycle after rd_en.
  always @(posedge clk) begin
    if (mem_wr_en) bram[mem_wr_addr] <= mem_wdata;
    if (mem_rd_en) mem_rdata <= bram[mem_rd_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({cmd_ready, busy, done, wdata_ready, rdata_valid, mem_rd_en, mem_wr_en} !== 7'b1000000) begin
      miscompares++;
      $display("FAIL reset_ctrl got %b want 1000000",
               {cmd_ready, busy, done, wdata_ready, rdata_valid, mem_rd_en, mem_wr_en});
    end
    vectors++;
    if ({rdata, mem_rd_addr, mem_wr_addr, mem_wdata} !== 56'h0) begin
      miscompares++;
      $display("FAIL reset_data got %h want 0", {rdata, mem_rd_addr, mem_wr_addr, mem_wdata});
    end
    rst = 1'b0;
    tick();
    vectors++;
    if ({cmd_ready, busy, done, mem_rd_en, mem_wr_en} !== 5'b10000) begin
      miscompares++;
      $display("FAIL post_reset_idle got %b want 10000", {cmd_ready, busy, done, mem_rd_en, mem_wr_en});
    end
  endtask

  task automatic test_write(input logic [11:0] addr, input int len, input bit fixed);
    logic [15:0] wd [256];
    int sent, tail, n;
    bit prev_acc, exp_busy, finished;
    for (int i = 0; i <= len; i++) begin
      wd[i] = fixed ? (16'hA000 + 16'(i)) : 16'($urandom);
      ref_mem[addr + 12'(i)] = wd[i];
    end
    cmd_write = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_valid = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_cmd_ready got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0;
    sent = 0; tail = 0; prev_acc = 1'b0; finished = 1'b0;
    for (n = 0; n < 10 * (len + 1) + 20 && !finished; n++) begin
      exp_busy = (sent <= len);
      vectors++;
      if ({busy, wdata_ready, cmd_ready} !== {exp_busy, exp_busy, !exp_busy}) begin
        miscompares++;
        $display("FAIL wr_state busy/wready/cready got %b want %b",
                 {busy, wdata_ready, cmd_ready}, {exp_busy, exp_busy, !exp_busy});
      end
      vectors++;
      if (mem_wr_en !== prev_acc || mem_rd_en !== 1'b0) begin
        miscompares++;
        $display("FAIL wr_strobe wr_en=%b rd_en=%b want wr_en=%b rd_en=0", mem_wr_en, mem_rd_en, prev_acc);
      end
      if (prev_acc) begin
        vectors++;
        if (mem_wr_addr !== addr + 12'(sent - 1) || mem_wdata !== wd[sent - 1]) begin
          miscompares++;
          $display("FAIL wr_beat got addr %h data %h want addr %h data %h",
                   mem_wr_addr, mem_wdata, addr + 12'(sent - 1), wd[sent - 1]);
        end
      end
      vectors++;
      if (done !== (prev_acc && sent == len + 1)) begin
        miscompares++;
        $display("FAIL wr_done got %b want %b", done, (prev_acc && sent == len + 1));
      end
      if (!exp_busy) begin
        tail++;
        if (tail > 2) finished = 1'b1;
      end
      wdata_valid = ($urandom_range(0, 3) != 0);
      wdata       = exp_busy ? wd[sent] : 16'($urandom);
      cmd_valid   = exp_busy && ($urandom_range(0, 1) == 1);
      cmd_write   = 1'($urandom_range(0, 1));
      cmd_addr    = 12'($urandom);
      cmd_len     = 8'($urandom);
      prev_acc    = wdata_valid && exp_busy;
      if (prev_acc) sent++;
      tick();
    end
    vectors++;
    if (!finished || sent != len + 1) begin
      miscompares++;
      $display("FAIL wr_timeout beats got %0d want %0d", sent, len + 1);
    end
    wdata_valid = 1'b0; cmd_valid = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready toggles, 2: random ready,
  // 3: ready low for the first 12 cycles then high.
  task automatic test_read(input logic [11:0] addr, input int len, input int mode);
    logic [15:0] exp_q [$];
    logic [15:0] prev_rdata;
    int issued, popped, done_cnt, s, tail;
    bit prev_stall, rdy, finished;
    for (int i = 0; i <= len; i++) exp_q.push_back(ref_mem[addr + 12'(i)]);
    cmd_write = 1'b0; cmd_addr = addr; cmd_len = 8'(len); cmd_valid = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_cmd_ready got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    issued = 0; popped = 0; done_cnt = 0; tail = 0;
    prev_stall = 1'b0; prev_rdata = '0; finished = 1'b0;
    for (s = 0; s < 40 * (len + 1) + 40 && !finished; s++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (s % 2 == 0);
        2:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = (s >= 12);
      endcase
      if (done === 1'b1) begin
        done_cnt++;
        vectors++;
        if (popped != len + 1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL rd_done_early popped %0d busy %b want %0d busy 0", popped, busy, len + 1);
        end
      end
      if (mem_rd_en === 1'b1) begin
        vectors++;
        if (issued > len || mem_rd_addr !== addr + 12'(issued)) begin
          miscompares++;
          $display("FAIL rd_issue got #%0d addr %h want <=%0d addr %h",
                   issued, mem_rd_addr, len, addr + 12'(issued));
        end
        issued++;
      end
      vectors++;
      if (mem_wr_en !== 1'b0 || cmd_ready !== !busy) begin
        miscompares++;
        $display("FAIL rd_ctrl wr_en %b cmd_ready %b busy %b", mem_wr_en, cmd_ready, busy);
      end
      if (prev_stall) begin
        vectors++;
        if (rdata_valid !== 1'b1 || rdata !== prev_rdata) begin
          miscompares++;
          $display("FAIL rd_hold got valid %b data %h want valid 1 data %h", rdata_valid, rdata, prev_rdata);
        end
      end
      if (mode == 0) begin
        vectors++;
        if (rdata_valid !== (s >= 2 && s <= len + 2) || done !== (s == len + 3)) begin
          miscompares++;
          $display("FAIL rd_timing cycle %0d got valid %b done %b want valid %b done %b",
                   s, rdata_valid, done, (s >= 2 && s <= len + 2), (s == len + 3));
        end
      end
      if (rdata_valid === 1'b1 && rdy) begin
        vectors++;
        if (popped > len || rdata !== exp_q[popped]) begin
          miscompares++;
          $display("FAIL rd_beat #%0d got %h want %h", popped, rdata, (popped > len) ? 16'hxxxx : exp_q[popped]);
        end
        popped++;
      end
      vectors++;
      if (issued - popped > 3) begin
        miscompares++;
        $display("FAIL rd_occupancy got %0d want <=3", issued - popped);
      end
      prev_stall = (rdata_valid === 1'b1) && !rdy;
      prev_rdata = rdata;
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) finished = 1'b1;
      end
      rdata_ready = rdy;
      wdata_valid = 1'($urandom_range(0, 1));
      wdata       = 16'($urandom);
      cmd_valid   = (busy === 1'b1) && ($urandom_range(0, 1) == 1);
      cmd_write   = 1'($urandom_range(0, 1));
      cmd_addr    = 12'($urandom);
      cmd_len     = 8'($urandom);
      tick();
    end
    vectors++;
    if (!finished || issued != len + 1 || popped != len + 1 || done_cnt != 1) begin
      miscompares++;
      $display("FAIL rd_summary issued %0d popped %0d done %0d want %0d %0d 1",
               issued, popped, done_cnt, len + 1, len + 1);
    end
    cmd_valid = 1'b0; wdata_valid = 1'b0; rdata_ready = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    logic [11:0] a;
    a = 12'h200;
    cmd_write = 1'b0; cmd_addr = a; cmd_len = 8'd7; cmd_valid = 1'b1; rdata_ready = 1'b1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_cmd_ready got %b want 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    repeat (4) tick();
    vectors++;
    if (rdata_valid !== 1'b1 || rdata !== ref_mem[a + 12'd2]) begin
      miscompares++;
      $display("FAIL rst_pre_beat got valid %b data %h want valid 1 data %h", rdata_valid, rdata, ref_mem[a + 12'd2]);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({cmd_ready, busy, done, wdata_ready, rdata_valid, mem_rd_en, mem_wr_en} !== 7'b1000000 || rdata !== 16'h0) begin
      miscompares++;
      $display("FAIL rst_async got %b rdata %h want 1000000 rdata 0",
               {cmd_ready, busy, done, wdata_ready, rdata_valid, mem_rd_en, mem_wr_en}, rdata);
    end
    tick();
    rst = 1'b0;
    vectors++;
    if ({cmd_ready, busy, done, rdata_valid, mem_rd_en, mem_wr_en} !== 6'b100000) begin
      miscompares++;
      $display("FAIL rst_held got %b want 100000", {cmd_ready, busy, done, rdata_valid, mem_rd_en, mem_wr_en});
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      vectors++;
      if ({cmd_ready, busy, done, rdata_valid, mem_rd_en, mem_wr_en} !== 6'b100000) begin
        miscompares++;
        $display("FAIL rst_quiet cycle %0d got %b want 100000", k,
                 {cmd_ready, busy, done, rdata_valid, mem_rd_en, mem_wr_en});
      end
    end
    rdata_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]    = 16'(i) ^ 16'h3C3C;
      ref_mem[i] = 16'(i) ^ 16'h3C3C;
    end
    test_reset();
    test_write(12'h0FE, 3, 1'b1);
    test_read(12'h0FE, 3, 0);
    test_write(12'h200, 7, 1'b0);
    test_read(12'h200, 7, 1);
    test_write(12'hFFF, 1, 1'b0);
    test_read(12'hFFF, 1, 0);
    test_reset_mid_read();
    test_read(12'h200, 7, 0);
    test_read(12'h0FE, 0, 3);
    for (int k = 0; k < 4; k++) begin
      logic [11:0] a;
      int l;
      a = 12'($urandom);
      l = $urandom_range(0, 20);
      test_write(a, l, 1'b0);
      test_read(a, l, 2);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
